// File: rtl/shift_reg_param.sv
// Parametrised universal shift register.
// In IDLE a 3-bit mode code selects hold, load, shift, rotate, arithmetic
// shift or clear. A start pulse loads p_in and runs a WIDTH-shift
// full-duplex serial transfer: the word leaves LSB-first on s_out while a
// new word enters from s_in at the MSB. A registered one-cycle done pulse
// follows the last shift.
module shift_reg_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] p_in,
  input  logic             s_in,
  input  logic             start,
  output logic [WIDTH-1:0] Q,
  output logic             s_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_SHL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_ROL   = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;

  // Next-state and datapath selection for both IDLE modes and the transfer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // start wins over mode and begins the transfer with the load.
          q_d     = p_in;
          cnt_d   = '0;
          state_d = XFER;
        end else begin
          unique case (mode_e'(mode))
            MODE_HOLD:  q_d = q_q;
            MODE_LOAD:  q_d = p_in;
            MODE_SHR:   q_d = {s_in, q_q[WIDTH-1:1]};
            MODE_SHL:   q_d = {q_q[WIDTH-2:0], s_in};
            MODE_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
            MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            MODE_ASR:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            MODE_CLEAR: q_d = '0;
            default:    q_d = q_q;
          endcase
        end
      end

      XFER: begin
        // mode and start are deliberately ignored for the whole transfer.
        q_d = {s_in, q_q[WIDTH-1:1]};
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, data and done registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign Q     = q_q;
  assign s_out = q_q[0];
  assign busy  = (state_q == XFER);
  assign done  = done_q;

endmodule

// File: tb/tb_shift_reg_param.sv
// Directed bench for shift_reg_param at WIDTH = 8, 2 and 32.
// Inputs change 1 ns after a rising edge; outputs are compared there too.
module tb_shift_reg_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH = 8 instance
  logic [2:0]  mode8 = 3'b000;
  logic [7:0]  p_in8 = '0;
  logic        s_in8 = 1'b0;
  logic        start8 = 1'b0;
  logic [7:0]  q8;
  logic        s_out8, busy8, done8;

  // WIDTH = 2 instance
  logic [2:0]  mode2 = 3'b000;
  logic [1:0]  p_in2 = '0;
  logic        s_in2 = 1'b0;
  logic        start2 = 1'b0;
  logic [1:0]  q2;
  logic        s_out2, busy2, done2;

  // WIDTH = 32 instance
  logic [2:0]  mode32 = 3'b000;
  logic [31:0] p_in32 = '0;
  logic        s_in32 = 1'b0;
  logic        start32 = 1'b0;
  logic [31:0] q32;
  logic        s_out32, busy32, done32;

  shift_reg_param #(.WIDTH(8)) d8 (
    .clk(clk), .rst(rst), .mode(mode8), .p_in(p_in8), .s_in(s_in8),
    .start(start8), .Q(q8), .s_out(s_out8), .busy(busy8), .done(done8)
  );

  shift_reg_param #(.WIDTH(2)) d2 (
    .clk(clk), .rst(rst), .mode(mode2), .p_in(p_in2), .s_in(s_in2),
    .start(start2), .Q(q2), .s_out(s_out2), .busy(busy2), .done(done2)
  );

  shift_reg_param #(.WIDTH(32)) d32 (
    .clk(clk), .rst(rst), .mode(mode32), .p_in(p_in32), .s_in(s_in32),
    .start(start32), .Q(q32), .s_out(s_out32), .busy(busy32), .done(done32)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] v);
    mode8 = 3'b001;
    p_in8 = v;
    tick();
  endtask

  task automatic mode_step(input string tag, input logic [2:0] m,
                           input logic [7:0] exp);
    load8(8'b1001_0110);
    mode8 = m;
    s_in8 = 1'b1;
    tick();
    check(tag, 32'(q8), 32'(exp));
  endtask

  logic [7:0]  a5    = 8'hA5;
  logic [7:0]  rx8   = 8'h8D;   // stream 1,0,1,1,0,0,0,1 LSB-first
  logic [7:0]  rx8b  = 8'h3C;
  logic [1:0]  tx2   = 2'b10;
  logic [31:0] tx32  = 32'hDEADBEEF;
  logic [31:0] rx32  = 32'h12345678;
  int          done_cnt;

  initial begin
    // Reset values
    #2;
    check("rst_q", 32'(q8), 32'h0);
    check("rst_sout", 32'(s_out8), 32'h0);
    check("rst_busy", 32'(busy8), 32'h0);
    check("rst_done", 32'(done8), 32'h0);
    tick();
    rst = 1'b0;

    // Mode sweep from 1001_0110 with s_in = 1
    mode_step("shr", 3'b010, 8'b1100_1011);
    mode_step("shl", 3'b011, 8'b0010_1101);
    mode_step("ror", 3'b100, 8'b0100_1011);
    mode_step("rol", 3'b101, 8'b0010_1101);
    mode_step("asr", 3'b110, 8'b1100_1011);
    mode_step("clr", 3'b111, 8'h00);
    mode_step("hold", 3'b000, 8'b1001_0110);
    mode8 = 3'b001;
    p_in8 = 8'h3C;
    tick();
    check("load", 32'(q8), 32'h3C);
    mode8 = 3'b000;

    // Auto-transfer of A5 receiving 8D
    start8 = 1'b1;
    p_in8  = 8'hA5;
    tick();                                   // edge k
    start8 = 1'b0;
    check("xf_load", 32'(q8), 32'hA5);
    for (int j = 0; j < 8; j++) begin
      check("xf_sout", 32'(s_out8), 32'(a5[j]));
      check("xf_busy", 32'(busy8), 32'h1);
      check("xf_done_lo", 32'(done8), 32'h0);
      s_in8 = rx8[j];
      tick();
    end
    check("xf_busy_end", 32'(busy8), 32'h0);
    check("xf_done", 32'(done8), 32'h1);
    check("xf_q", 32'(q8), 32'h8D);
    tick();
    check("xf_done_clr", 32'(done8), 32'h0);

    // Inputs ignored while busy: mode=111 and toggling start
    start8 = 1'b1;
    p_in8  = 8'h5A;
    tick();
    done_cnt = 0;
    mode8 = 3'b111;
    for (int j = 0; j < 8; j++) begin
      start8 = j[0];
      s_in8  = rx8b[j];
      tick();
      if (done8) done_cnt++;
      if (j < 7) check("ign_busy", 32'(busy8), 32'h1);
    end
    start8 = 1'b0;
    mode8  = 3'b000;
    check("ign_done", 32'(done8), 32'h1);
    check("ign_q", 32'(q8), 32'h3C);
    tick();
    if (done8) done_cnt++;
    check("ign_done_once", 32'(done_cnt), 32'd1);
    check("ign_q_hold", 32'(q8), 32'h3C);

    // Back-to-back: second start in the done cycle
    start8 = 1'b1;
    p_in8  = 8'hA5;
    tick();
    start8 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      s_in8 = rx8[j];
      tick();
    end
    check("b2b_done1", 32'(done8), 32'h1);
    check("b2b_busy_gap", 32'(busy8), 32'h0);
    start8 = 1'b1;
    p_in8  = 8'hFF;
    tick();
    start8 = 1'b0;
    check("b2b_busy2", 32'(busy8), 32'h1);
    check("b2b_done_drop", 32'(done8), 32'h0);
    check("b2b_load2", 32'(q8), 32'hFF);
    for (int j = 0; j < 8; j++) begin
      s_in8 = 1'b0;
      check("b2b_sout2", 32'(s_out8), 32'h1);
      tick();
    end
    check("b2b_done2", 32'(done8), 32'h1);
    check("b2b_q2", 32'(q8), 32'h00);
    tick();
    check("b2b_done2_clr", 32'(done8), 32'h0);

    // Reset mid-transfer at the 3rd shift
    start8 = 1'b1;
    p_in8  = 8'hA5;
    tick();                                   // edge k
    start8 = 1'b0;
    tick();                                   // k+1
    tick();                                   // k+2
    rst = 1'b1;
    #1;
    check("mid_rst_q", 32'(q8), 32'h0);
    check("mid_rst_busy", 32'(busy8), 32'h0);
    check("mid_rst_done", 32'(done8), 32'h0);
    tick();
    tick();
    check("mid_rst_done_hold", 32'(done8), 32'h0);
    rst   = 1'b0;
    mode8 = 3'b001;
    p_in8 = 8'h77;
    tick();
    check("post_rst_load", 32'(q8), 32'h77);
    check("post_rst_busy", 32'(busy8), 32'h0);
    check("post_rst_done", 32'(done8), 32'h0);
    mode8 = 3'b000;

    // WIDTH = 2 transfer of 2'b10, receiving 2'b11
    start2 = 1'b1;
    p_in2  = tx2;
    tick();
    start2 = 1'b0;
    check("w2_busy", 32'(busy2), 32'h1);
    check("w2_sout0", 32'(s_out2), 32'h0);
    s_in2 = 1'b1;
    tick();
    check("w2_sout1", 32'(s_out2), 32'h1);
    check("w2_done_lo", 32'(done2), 32'h0);
    tick();
    check("w2_done", 32'(done2), 32'h1);
    check("w2_busy_end", 32'(busy2), 32'h0);
    check("w2_q", 32'(q2), 32'h3);
    tick();
    check("w2_done_clr", 32'(done2), 32'h0);

    // WIDTH = 32 transfer of DEADBEEF, receiving 12345678
    start32 = 1'b1;
    p_in32  = tx32;
    tick();
    start32 = 1'b0;
    for (int j = 0; j < 32; j++) begin
      check("w32_sout", 32'(s_out32), 32'(tx32[j]));
      check("w32_done_lo", 32'(done32), 32'h0);
      s_in32 = rx32[j];
      tick();
    end
    check("w32_done", 32'(done32), 32'h1);
    check("w32_busy_end", 32'(busy32), 32'h0);
    check("w32_q", q32, 32'h12345678);
    tick();
    check("w32_done_clr", 32'(done32), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
